// File: rtl/rwc_pkg.sv
// Shared types and constants for the read-write-collision challenge sequencer.
// Optional build macro used by the sequencer: RWC_MAJORITY_VOTE_EN.
package rwc_pkg;

    localparam int RWC_ADDR_W = 10;
    localparam int RWC_DATA_W = 32;

    localparam logic [RWC_DATA_W-1:0] RWC_LFSR_POLY    = 32'h8020_0003;
    localparam logic [RWC_DATA_W-1:0] RWC_DEFAULT_SEED = 32'h0000_0001;

    typedef logic [2:0] rwc_state_t;

    localparam rwc_state_t ST_IDLE    = 3'd0;
    localparam rwc_state_t ST_ISSUE   = 3'd1;
    localparam rwc_state_t ST_WAIT_LO = 3'd2;
    localparam rwc_state_t ST_WAIT_HI = 3'd3;
    localparam rwc_state_t ST_SETTLE  = 3'd4;
    localparam rwc_state_t ST_CAPTURE = 3'd5;
    localparam rwc_state_t ST_OUTPUT  = 3'd6;

    // Galois right-shift step; the polynomial taps are folded in when bit 0 shifts out.
    function automatic logic [RWC_DATA_W-1:0] lfsr_next(input logic [RWC_DATA_W-1:0] x);
        return (x >> 1) ^ (x[0] ? RWC_LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/rwc_lfsr32.sv
// 32-bit challenge LFSR with load/step control; an all-zero seed would lock up,
// so it is replaced by the default seed on load.
module rwc_lfsr32
    import rwc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [RWC_DATA_W-1:0] seed,
    output logic [RWC_DATA_W-1:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= (seed == '0) ? RWC_DEFAULT_SEED : seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/rwc_chal_seq.sv
// Challenge sequencer / response collector for the RWC PUF generator.
// Build macro RWC_MAJORITY_VOTE_EN: evaluate each challenge three times and vote 2-of-3.
module rwc_chal_seq
    import rwc_pkg::*;
#(
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           num_chal,
    input  logic [RWC_DATA_W-1:0] seed,
    input  logic [RWC_ADDR_W-1:0] addr_base,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  gen_enable,
    output logic [RWC_DATA_W-1:0] cha_data,
    output logic [RWC_ADDR_W-1:0] cha_addr,
    input  logic                  available,
    input  logic [RWC_DATA_W-1:0] rsp_in,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RWC_DATA_W-1:0] rsp_data,
    output logic [RWC_ADDR_W-1:0] rsp_addr,
    output logic [15:0]           rsp_index
);

    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CYC - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    rwc_state_t  state;
    logic [15:0] num_q;
    logic [15:0] idx;
    logic [7:0]  tmo_cnt;
    logic [3:0]  settle_cnt;
    logic        last;
    logic        lfsr_load;
    logic        lfsr_step;

`ifdef RWC_MAJORITY_VOTE_EN
    logic [1:0]            pass_q;
    logic [RWC_DATA_W-1:0] vote0;
    logic [RWC_DATA_W-1:0] vote1;
`endif

    assign last      = (idx == num_q - 16'd1);
    assign lfsr_load = (state == ST_IDLE) && start;
    assign lfsr_step = (state == ST_OUTPUT) && rsp_ready && !last;

    rwc_lfsr32 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (seed),
        .state (cha_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            num_q      <= '0;
            idx        <= '0;
            tmo_cnt    <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            gen_enable <= 1'b0;
            cha_addr   <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_addr   <= '0;
            rsp_index  <= '0;
`ifdef RWC_MAJORITY_VOTE_EN
            pass_q     <= '0;
            vote0      <= '0;
            vote1      <= '0;
`endif
        end else begin
            // NOTE: strobes default low here and are re-asserted below only in their one cycle;
            // non-blocking assignment makes the later write win without ordering hazards.
            done       <= 1'b0;
            gen_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        error    <= 1'b0;
                        num_q    <= num_chal;
                        idx      <= '0;
                        cha_addr <= addr_base;
`ifdef RWC_MAJORITY_VOTE_EN
                        pass_q   <= '0;
`endif
                        if (num_chal == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            busy       <= 1'b1;
                            gen_enable <= 1'b1;
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT_LO;
                end
                ST_WAIT_LO, ST_WAIT_HI: begin
                    if ((state == ST_WAIT_LO) ? !available : available) begin
                        tmo_cnt    <= '0;
                        settle_cnt <= '0;
                        state      <= (state == ST_WAIT_LO) ? ST_WAIT_HI : ST_SETTLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Generator never answered: abort the run with no response emitted.
                        error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_CAPTURE: begin
`ifdef RWC_MAJORITY_VOTE_EN
                    if (pass_q != 2'd2) begin
                        if (pass_q == 2'd0) vote0 <= rsp_in;
                        else                vote1 <= rsp_in;
                        pass_q     <= pass_q + 2'd1;
                        gen_enable <= 1'b1;
                        state      <= ST_ISSUE;
                    end else begin
                        rsp_data  <= (vote0 & vote1) | (vote0 & rsp_in) | (vote1 & rsp_in);
                        rsp_addr  <= cha_addr;
                        rsp_index <= idx;
                        rsp_valid <= 1'b1;
                        pass_q    <= '0;
                        state     <= ST_OUTPUT;
                    end
`else
                    rsp_data  <= rsp_in;
                    rsp_addr  <= cha_addr;
                    rsp_index <= idx;
                    rsp_valid <= 1'b1;
                    state     <= ST_OUTPUT;
`endif
                end
                ST_OUTPUT: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (last) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            idx        <= idx + 16'd1;
                            cha_addr   <= cha_addr + 10'd1;
                            gen_enable <= 1'b1;
                            state      <= ST_ISSUE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rwc_chal_seq.md
# rwc_chal_seq

Challenge sequencer and response collector for the read-write-collision PUF generator. Produces a run of challenges (32-bit LFSR data, incrementing 10-bit BRAM address) and drives the generator's `gen_enable`/`available` handshake. Captures each response and presents it on a valid/ready stream toward the host/UART side. Sits between the host command logic and the PUF generator controller, in the same clock domain.

## Interface
- `SETTLE_CYC`, default 2: cycles waited after `available` returns high before `rsp_in` is sampled (1..15).
- `TIMEOUT_CYC`, default 16: maximum cycles allowed in each generator wait phase (2..255).
- `clk` input 1: single system clock, also the generator's `clk`.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: one-cycle run request; sampled only in IDLE.
- `num_chal` input 16: challenges in the run, latched on `start`.
- `seed` input 32: LFSR seed, latched on `start`; 0 is replaced by 32'h0000_0001.
- `addr_base` input 10: first BRAM address, latched on `start`.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse at run end, including aborts.
- `error` output 1: sticky timeout flag; cleared by the next accepted `start`.
- `gen_enable` output 1: one-cycle challenge strobe to the generator.
- `cha_data` output 32: challenge data.
- `cha_addr` output 10: challenge address.
- `available` input 1: generator idle indication.
- `rsp_in` input 32: generator response (`rsp_pos`).
- `rsp_valid` output 1: output word valid.
- `rsp_ready` input 1: consumer accepts the word when `rsp_valid` and `rsp_ready` are both high.
- `rsp_data` output 32: captured response.
- `rsp_addr` output 10: address that produced `rsp_data`.
- `rsp_index` output 16: 0-based challenge index within the run.

## Operation
- FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI, SETTLE, CAPTURE, OUTPUT.
- **IDLE**: on `start`, latch inputs and clear `error`.
  - If `num_chal==0`: pulse `done` next cycle and stay IDLE.
  - Otherwise go to ISSUE.
- **ISSUE**: `gen_enable=1` for exactly this cycle, then WAIT_LO. `cha_data`/`cha_addr` are stable from ISSUE through CAPTURE.
- **WAIT_LO**: wait for `available==0`, then WAIT_HI.
- **WAIT_HI**: wait for `available==1`, then SETTLE.
- **SETTLE**: count `SETTLE_CYC` cycles, then CAPTURE.
- **CAPTURE**: register `rsp_in`, `cha_addr` and the index into the output buffer, then OUTPUT.
- **OUTPUT**: hold `rsp_valid` until accepted. On acceptance:
  - If this was the last challenge: pulse `done` and go to IDLE.
  - Otherwise advance LFSR and address, then go to ISSUE.
- Challenge data:
  - First challenge = seed.
  - Each following challenge uses a Galois right-shift LFSR: `next = (x>>1) ^ (x[0] ? 32'h8020_0003 : 0)`.
- Address: `addr_base + index` modulo 1024; wraps from 1023 to 0 with no flag.
- Timeout: a counter runs in WAIT_LO and WAIT_HI and restarts on each entry. When it reaches `TIMEOUT_CYC`:
  - set `error`, pulse `done`, go to IDLE;
  - no response is emitted for that challenge.
- `start` while `busy` is ignored.
- `rsp_ready` held low stalls the run indefinitely; this does not count toward the timeout.

## Timing
- Reset: every output is 0 (`busy`, `done`, `error`, `gen_enable`, `cha_data`, `cha_addr`, `rsp_valid`, `rsp_data`, `rsp_addr`, `rsp_index`); FSM in IDLE.
- Reset asserted mid-run aborts immediately, with no `done` pulse.
- `start` at cycle 0 gives `busy` and `gen_enable` high at cycle 1.
- With a generator whose `available` drops at cycle 1 and rises at cycle 5 (one 4-state pass), `rsp_valid` rises at 5+`SETTLE_CYC`+2. With `SETTLE_CYC`=2 that is cycle 9.
- After acceptance at cycle N, the next `gen_enable` occurs at cycle N+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `RWC_MAJORITY_VOTE_EN` defined: each challenge runs ISSUE→CAPTURE three times with identical data and address. `rsp_data` is the bitwise 2-of-3 majority of the three captures. A timeout in any of the three passes aborts the run.
- Undefined: single evaluation per challenge; the vote logic and the repeat counter are absent.

## Structure
- Shared package `rwc_pkg`:
  - state enum;
  - `RWC_LFSR_POLY = 32'h8020_0003`;
  - address and data widths (10, 32);
  - default seed 32'h1.
- One sub-module, `rwc_lfsr32`: load, step and state, with zero-seed substitution.

## Test plan
- Seed 32'h1, `num_chal`=2, `addr_base`=0, `rsp_ready`=1, behavioural generator model → two responses with `cha_data` 32'h0000_0001 then 32'h8020_0003, `rsp_addr` 0 then 1, `rsp_index` 0 then 1, one `done` pulse.
- `num_chal`=0 → `done` pulse one cycle after `start`, no `gen_enable`, `busy` never high.
- `addr_base`=10'd1022, `num_chal`=3 → `rsp_addr` 1022, 1023, 0.
- `available` stuck high → `error`=1 and `done` pulse `TIMEOUT_CYC` cycles after the WAIT_LO entry; `rsp_valid` never rises; the next `start` clears `error`.
- `rsp_ready` low for 20 cycles → `rsp_valid` and `rsp_data` held stable, no `gen_enable`; next challenge issued the cycle after acceptance.
- With `RWC_MAJORITY_VOTE_EN` and a model returning 32'hF0, 32'hFF, 32'h0F for the three passes → `rsp_data`=32'hFF and exactly 3 `gen_enable` pulses.
